// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller: FSM state encoding and
// stop-cause codes reported on stop_cause.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } run_state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_LIMIT = 2'b01;
  localparam logic [1:0] CAUSE_OVF   = 2'b10;
  localparam logic [1:0] CAUSE_EXT   = 2'b11;

endpackage

// File: rtl/ce_divider.sv
// Free-running phase counter producing a one-cycle clock-enable every DIV
// cycles; phase is held at zero whenever enable is low.
module ce_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic ce
);

  localparam int              PH_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);

  logic [PH_W-1:0] phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            phase <= '0;
    else if (!enable || phase == PH_LAST) phase <= '0;
    else                                  phase <= phase + 1'b1;
  end

  assign ce = enable && (phase == PH_LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for a slow CPU core: reset sequencing, divided clock-enable,
// single-step, cycle limit and stop-cause capture.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | CPU held in reset, waiting for start
//   ST_RESET | CPU reset asserted for RST_CYCLES base cycles
//   ST_RUN   | free run, cpu_ce every DIV base cycles
//   ST_STEP  | one cpu_ce per rising edge of step
//   ST_DONE  | stopped, results frozen until the next start
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV        = 2,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop_req,
  input  logic              step_mode,
  input  logic              step,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic              trap_of_en,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              of,
  input  logic              zf,
  output logic              cpu_ce,
  output logic              cpu_rst,
  output logic              running,
  output logic              done,
  output logic [1:0]        stop_cause,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [DATA_W-1:0] last_alu_f,
  output logic              last_of,
  output logic              last_zf
);

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

  run_state_t       state, state_nxt;
  logic [7:0]       rst_cnt;
  logic             step_q, step_pend, div_ce, start_acc;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       cause_hit;

  assign running   = (state == ST_RUN) || (state == ST_STEP);
  assign done      = (state == ST_DONE);
  assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign cnt_inc   = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;

  ce_divider #(.DIV(DIV)) u_ce_div (
    .clk    (clk),
    .rst    (rst),
    .enable (state == ST_RUN),
    .ce     (div_ce)
  );

  always_comb begin
    state_nxt = state;
    cpu_ce    = 1'b0;
    cpu_rst   = 1'b0;
    cause_hit = CAUSE_NONE;
    case (state)
      ST_IDLE: begin
        cpu_rst = 1'b1;
        if (start) state_nxt = ST_RESET;
      end
      ST_RESET: begin
        cpu_rst = 1'b1;
        if (rst_cnt == '0) state_nxt = step_mode ? ST_STEP : ST_RUN;
      end
      ST_RUN: begin
        cpu_ce = div_ce;
        // leave for STEP only on a phase wrap so no partial CPU cycle is lost
        if (div_ce && step_mode) state_nxt = ST_STEP;
      end
      ST_STEP: begin
        cpu_ce = step_pend;
        if (!step_mode) state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_nxt = ST_RESET;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (running) begin
      if (stop_req)                                                   cause_hit = CAUSE_EXT;
      else if (cpu_ce && trap_of_en && of)                            cause_hit = CAUSE_OVF;
      else if (cpu_ce && (max_cycles != '0) && (cnt_inc == max_cycles)) cause_hit = CAUSE_LIMIT;
      if (cause_hit != CAUSE_NONE) state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rst_cnt    <= '0;
      step_q     <= 1'b0;
      step_pend  <= 1'b0;
      cycle_cnt  <= '0;
      last_alu_f <= '0;
      last_of    <= 1'b0;
      last_zf    <= 1'b0;
      stop_cause <= CAUSE_NONE;
    end else begin
      state     <= state_nxt;
      step_q    <= step;
      step_pend <= (state == ST_STEP) && step && !step_q;
      if (start_acc) begin
        rst_cnt    <= RST_LOAD;
        cycle_cnt  <= '0;
        last_alu_f <= '0;
        last_of    <= 1'b0;
        last_zf    <= 1'b0;
        stop_cause <= CAUSE_NONE;
      end else begin
        if ((state == ST_RESET) && (rst_cnt != '0)) rst_cnt <= rst_cnt - 1'b1;
        if (cpu_ce) begin
          cycle_cnt  <= cnt_inc;
          last_alu_f <= alu_f;
          last_of    <= of;
          last_zf    <= zf;
        end
        if (cause_hit != CAUSE_NONE) stop_cause <= cause_hit;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl; a second instance with a 4-bit cycle
// counter shares the stimulus and is checked for counter saturation.
module tb_cpu_run_ctrl;

  localparam int DIV = 2;

  logic        clk, rst;
  logic        start, stop_req, step_mode, step, trap_of_en, of, zf;
  logic [15:0] max_cycles;
  logic [31:0] alu_f;

  logic        cpu_ce, cpu_rst, running, done, last_of, last_zf;
  logic [1:0]  stop_cause;
  logic [15:0] cycle_cnt;
  logic [31:0] last_alu_f;

  logic        cpu_ce4, cpu_rst4, running4, done4, last_of4, last_zf4;
  logic [1:0]  stop_cause4;
  logic [3:0]  cycle_cnt4;
  logic [31:0] last_alu_f4;

  cpu_run_ctrl #(.DATA_W(32), .DIV(DIV), .RST_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .step_mode(step_mode), .step(step), .max_cycles(max_cycles),
    .trap_of_en(trap_of_en), .alu_f(alu_f), .of(of), .zf(zf),
    .cpu_ce(cpu_ce), .cpu_rst(cpu_rst), .running(running), .done(done),
    .stop_cause(stop_cause), .cycle_cnt(cycle_cnt), .last_alu_f(last_alu_f),
    .last_of(last_of), .last_zf(last_zf)
  );

  cpu_run_ctrl #(.DATA_W(32), .DIV(DIV), .RST_CYCLES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .step_mode(step_mode), .step(step), .max_cycles(4'd0),
    .trap_of_en(trap_of_en), .alu_f(alu_f), .of(of), .zf(zf),
    .cpu_ce(cpu_ce4), .cpu_rst(cpu_rst4), .running(running4), .done(done4),
    .stop_cause(stop_cause4), .cycle_cnt(cycle_cnt4), .last_alu_f(last_alu_f4),
    .last_of(last_of4), .last_zf(last_zf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int w_nce, w_bad, w_done, w_first, w_lat, w_rst, n;
  logic [31:0] w_alu;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; stop_req = 1'b0; step_mode = 1'b0; step = 1'b0;
    trap_of_en = 1'b0; of = 1'b0; zf = 1'b0; max_cycles = '0; alu_f = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // pulse start, then count cpu_rst cycles until the FSM reaches RUN/STEP
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    w_rst = 0;
    for (int i = 0; i < 20; i++) begin
      if (running) break;
      if (cpu_rst) w_rst++;
      tick();
    end
  endtask

  // of / stop_req are raised in the same cycle as the chosen cpu_ce
  task automatic run_watch(input int budget, input int of_at, input int stop_at, input int quit_at);
    int prev;
    w_nce = 0; w_bad = 0; w_done = 0; w_first = -1; w_lat = -1; prev = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      of = 1'b0; stop_req = 1'b0;
      alu_f = 32'hA500_0000 | 32'(cyc);
      if (done) begin
        w_done = 1;
        w_lat = i - prev;
        break;
      end
      if (cpu_ce) begin
        w_nce++;
        if (w_first < 0) w_first = i;
        if (prev >= 0 && (i - prev) != DIV) w_bad++;
        prev = i;
        w_alu = alu_f;
        zf = w_nce[0];
        of = (w_nce == of_at);
        stop_req = (w_nce == stop_at);
      end
      if (quit_at != 0 && w_nce == quit_at) break;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop_req = 1'b0; step_mode = 1'b0; step = 1'b0;
    trap_of_en = 1'b0; of = 1'b0; zf = 1'b0; max_cycles = '0; alu_f = '0;
    tick();
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_cpu_ce", cpu_ce, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cause", stop_cause, 2'b00);
    check("rst_cnt", cycle_cnt, 16'd0);

    // cycle limit of 5
    do_reset();
    max_cycles = 16'd5;
    start_run();
    check("lim_rst_cycles", w_rst, 4);
    check("lim_cpu_rst_run", cpu_rst, 1'b0);
    run_watch(100, 0, 0, 0);
    check("lim_first_ce", w_first, 1);
    check("lim_ce_gap", w_bad, 0);
    check("lim_nce", w_nce, 5);
    check("lim_done", w_done, 1);
    check("lim_done_lat", w_lat, 1);
    check("lim_cnt", cycle_cnt, 16'd5);
    check("lim_cause", stop_cause, 2'b01);
    check("lim_alu", last_alu_f, w_alu);
    check("lim_done_cpu_rst", cpu_rst, 1'b0);
    tick(); tick();
    check("lim_frozen_cnt", cycle_cnt, 16'd5);

    // overflow trap at the 3rd cpu_ce, no limit
    do_reset();
    trap_of_en = 1'b1;
    start_run();
    run_watch(200, 3, 0, 0);
    check("ovf_done", w_done, 1);
    check("ovf_cause", stop_cause, 2'b10);
    check("ovf_cnt", cycle_cnt, 16'd3);
    check("ovf_last_of", last_of, 1'b1);
    check("ovf_last_zf", last_zf, 1'b1);
    check("ovf_alu", last_alu_f, w_alu);

    // restart from DONE; external stop coincident with an overflow cpu_ce
    start_run();
    check("ext_cause_clr", stop_cause, 2'b00);
    check("ext_cnt_clr", cycle_cnt, 16'd0);
    check("ext_of_clr", last_of, 1'b0);
    run_watch(200, 2, 2, 0);
    check("ext_done", w_done, 1);
    check("ext_cause", stop_cause, 2'b11);
    check("ext_cnt", cycle_cnt, 16'd2);

    // single-step: one long step then three pulses, then back to free run
    do_reset();
    step_mode = 1'b1;
    start_run();
    check("stp_running", running, 1'b1);
    n = 0;
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) check("stp_ce_lat", cpu_ce, 1'b1);
      if (cpu_ce) n++;
    end
    step = 1'b0;
    tick(); if (cpu_ce) n++;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1; tick(); if (cpu_ce) n++;
      step = 1'b0; tick(); if (cpu_ce) n++;
      tick(); if (cpu_ce) n++;
    end
    check("stp_nce", n, 4);
    check("stp_cnt", cycle_cnt, 16'd4);
    step_mode = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ce) n++;
    end
    check("stp_free_nce", n, 5);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    check("stp_stop_done", done, 1'b1);
    check("stp_stop_cause", stop_cause, 2'b11);
    check("stp_stop_cnt", cycle_cnt, 16'd9);

    // asynchronous reset in the middle of a run
    do_reset();
    start_run();
    run_watch(100, 0, 0, 7);
    tick();
    check("mid_cnt_before", cycle_cnt, 16'd7);
    rst = 1'b0;
    #1;
    check("mid_cnt", cycle_cnt, 16'd0);
    check("mid_cpu_rst", cpu_rst, 1'b1);
    check("mid_running", running, 1'b0);
    check("mid_alu", last_alu_f, 32'd0);
    check("mid_cpu_ce", cpu_ce, 1'b0);
    #3;
    rst = 1'b1;
    tick();
    start_run();
    check("mid_restart_cnt", cycle_cnt, 16'd0);
    run_watch(100, 0, 0, 2);
    tick();
    check("mid_restart_cnt2", cycle_cnt, 16'd2);

    // 4-bit counter saturates without stopping
    do_reset();
    start_run();
    run_watch(100, 0, 0, 20);
    tick();
    check("sat_cnt16", cycle_cnt, 16'd20);
    check("sat_cnt4", cycle_cnt4, 4'd15);
    check("sat_running4", running4, 1'b1);
    check("sat_done4", done4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
